// File: rtl/mod_updown_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mod_updown_counter
// Description : Parametrised up/down modulo counter with synchronous load,
//               enable, prescaler, wrap/saturate mode, terminal-count pulse
//               and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              PRESCALE = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_max_val  = MAX_VAL[WIDTH-1:0];
    localparam logic [15:0]      c_pre_last = 16'(PRESCALE - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic [15:0]      r_pre;

    logic             w_pre_wrap;
    logic [15:0]      w_pre_next;
    logic             w_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_boundary;
    logic [WIDTH-1:0] w_count_step;
    logic [WIDTH-1:0] w_load_val;
    logic             w_ovf_next;

    // A step fires on the enabled edge where the prescaler sits at its last value.
    assign w_pre_wrap = (r_pre == c_pre_last);
    assign w_pre_next = w_pre_wrap ? 16'd0 : (r_pre + 16'd1);
    assign w_step     = en && !load && w_pre_wrap;

    assign w_at_max   = (r_count == c_max_val);
    assign w_at_zero  = (r_count == '0);
    assign w_boundary = w_step && (up ? w_at_max : w_at_zero);

    assign w_load_val = (load_data > c_max_val) ? c_max_val : load_data;

    // Set has priority over clear so a coincident boundary event is never lost.
    assign w_ovf_next = w_boundary ? 1'b1 : (clear_ovf ? 1'b0 : r_ovf);

    always_comb begin
        w_count_step = r_count;
        if (up) begin
            if (w_at_max) begin
                w_count_step = SATURATE ? c_max_val : '0;
            end else begin
                w_count_step = r_count + WIDTH'(1);
            end
        end else begin
            if (w_at_zero) begin
                w_count_step = SATURATE ? '0 : c_max_val;
            end else begin
                w_count_step = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_pre   <= 16'd0;
        end else begin
            r_ovf <= w_ovf_next;
            if (load) begin
                r_count <= w_load_val;
                r_pre   <= 16'd0;
                r_tc    <= 1'b0;
            end else begin
                if (en) begin
                    r_pre <= w_pre_next;
                end
                if (w_step) begin
                    r_count <= w_count_step;
                end
                r_tc <= w_boundary;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mod_updown_counter
// Description : Scoreboard bench driving four counter configurations in
//               parallel against a behavioural model plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

    typedef struct packed {
        logic [1:0] inst;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_data;
    logic       clear_ovf;

    logic [3:0] count_o [4];
    logic       tc_o    [4];
    logic       ovf_o   [4];

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    // Model parameters per instance: wrap/9, saturate/9, prescale3/9, natural 15.
    int p_max [4] = '{9, 9, 9, 15};
    int p_ps  [4] = '{1, 1, 3, 1};
    int p_sat [4] = '{0, 1, 0, 0};

    int m_cnt [4];
    int m_pre [4];
    bit m_tc  [4];
    bit m_ovf [4];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_data(load_data),
        .clear_ovf(clear_ovf), .count(count_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_data(load_data),
        .clear_ovf(clear_ovf), .count(count_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(1'b0)) u_dut_pre (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_data(load_data),
        .clear_ovf(clear_ovf), .count(count_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

    mod_updown_counter #(.WIDTH(4)) u_dut_nat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_data(load_data),
        .clear_ovf(clear_ovf), .count(count_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit u, input bit l,
                                input int ld, input bit c);
        bit stp;
        bit bnd;
        for (int k = 0; k < 4; k++) begin
            stp = 1'b0;
            bnd = 1'b0;
            if (r) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = (ld > p_max[k]) ? p_max[k] : ld;
                m_pre[k] = 0;
                m_tc[k]  = 1'b0;
                if (c) m_ovf[k] = 1'b0;
            end else begin
                if (e) begin
                    m_pre[k] = m_pre[k] + 1;
                    if (m_pre[k] == p_ps[k]) begin
                        m_pre[k] = 0;
                        stp = 1'b1;
                    end
                end
                if (stp && u) begin
                    if (m_cnt[k] == p_max[k]) begin
                        bnd = 1'b1;
                        m_cnt[k] = (p_sat[k] != 0) ? p_max[k] : 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else if (stp) begin
                    if (m_cnt[k] == 0) begin
                        bnd = 1'b1;
                        m_cnt[k] = (p_sat[k] != 0) ? 0 : p_max[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
                m_tc[k] = bnd;
                if (bnd) m_ovf[k] = 1'b1;
                else if (c) m_ovf[k] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare every instance after the edge.
    task automatic cycle(input bit r, input bit e, input bit u, input bit l,
                         input logic [3:0] ld, input bit c);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; up = u; load = l; load_data = ld; clear_ovf = c;
        model_update(r, e, u, l, int'(ld), c);
        for (int k = 0; k < 4; k++) begin
            x.inst = 2'(k);
            x.cnt  = 4'(m_cnt[k]);
            x.tc   = m_tc[k];
            x.ovf  = m_ovf[k];
            sb_q.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            x = sb_q.pop_front();
            check_val($sformatf("sb%0d_count", x.inst), 32'(count_o[x.inst]), 32'(x.cnt));
            check_val($sformatf("sb%0d_tc", x.inst), 32'(tc_o[x.inst]), 32'(x.tc));
            check_val($sformatf("sb%0d_ovf", x.inst), 32'(ovf_o[x.inst]), 32'(x.ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int sat_exp [5] = '{8, 9, 9, 9, 9};
        bit pre_en  [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        int pre_exp [9] = '{0, 0, 1, 1, 1, 1, 1, 2, 2};

        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_data = 4'd0; clear_ovf = 1'b0;

        cycle(1, 0, 1, 0, 4'd0, 0);
        cycle(1, 0, 1, 0, 4'd0, 0);
        for (int k = 0; k < 4; k++) begin
            check_val("rst_count", 32'(count_o[k]), 0);
            check_val("rst_tc", 32'(tc_o[k]), 0);
            check_val("rst_ovf", 32'(ovf_o[k]), 0);
        end

        // Count up through the modulo-10 wrap.
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 1, 1, 0, 4'd0, 0);
            check_val("up_count", 32'(count_o[0]), 32'(i % 10));
            check_val("up_tc", 32'(tc_o[0]), (i == 10) ? 32'd1 : 32'd0);
            check_val("nat_count", 32'(count_o[3]), 32'(i));
        end
        check_val("up_ovf", 32'(ovf_o[0]), 1);

        // Clear, then a down wrap coinciding with clear_ovf.
        cycle(0, 0, 1, 0, 4'd0, 1);
        check_val("clr_ovf", 32'(ovf_o[0]), 0);
        cycle(0, 0, 0, 1, 4'd0, 0);
        check_val("ld0_count", 32'(count_o[0]), 0);
        cycle(0, 1, 0, 0, 4'd0, 1);
        check_val("dn_wrap_count", 32'(count_o[0]), 9);
        check_val("dn_wrap_tc", 32'(tc_o[0]), 1);
        check_val("set_wins_ovf", 32'(ovf_o[0]), 1);
        cycle(0, 1, 0, 0, 4'd0, 0);
        check_val("dn_count8", 32'(count_o[0]), 8);
        check_val("dn_tc8", 32'(tc_o[0]), 0);
        cycle(0, 1, 0, 0, 4'd0, 0);
        check_val("dn_count7", 32'(count_o[0]), 7);

        // Saturation at MAX_VAL.
        cycle(0, 0, 1, 0, 4'd0, 1);
        check_val("sat_clr_ovf", 32'(ovf_o[1]), 0);
        cycle(0, 0, 1, 1, 4'd7, 0);
        check_val("sat_ld7", 32'(count_o[1]), 7);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 0, 4'd0, 0);
            check_val("sat_count", 32'(count_o[1]), 32'(sat_exp[i]));
            check_val("sat_tc", 32'(tc_o[1]), (i >= 2) ? 32'd1 : 32'd0);
        end
        check_val("sat_ovf", 32'(ovf_o[1]), 1);

        // Load clamp and load-over-step priority.
        cycle(0, 0, 1, 1, 4'hD, 0);
        check_val("clamp_count", 32'(count_o[0]), 9);
        check_val("clamp_tc", 32'(tc_o[0]), 0);
        check_val("clamp_ovf", 32'(ovf_o[0]), 1);
        check_val("noclamp_nat", 32'(count_o[3]), 13);
        cycle(0, 1, 1, 1, 4'd3, 0);
        check_val("ld_en_count", 32'(count_o[0]), 3);
        cycle(0, 1, 1, 1, 4'd3, 0);
        check_val("ld_hold_count", 32'(count_o[0]), 3);
        check_val("ld_hold_pre", 32'(count_o[2]), 3);

        // Prescaler with a two-cycle enable gap.
        cycle(0, 0, 1, 1, 4'd0, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(0, pre_en[i], 1, 0, 4'd0, 0);
            check_val("pre_count", 32'(count_o[2]), 32'(pre_exp[i]));
        end

        // Reset mid-count and mid-prescale.
        cycle(0, 0, 1, 1, 4'd4, 0);
        cycle(0, 1, 1, 0, 4'd0, 0);
        check_val("mid_count", 32'(count_o[0]), 5);
        check_val("mid_ovf", 32'(ovf_o[0]), 1);
        cycle(1, 1, 1, 0, 4'd0, 0);
        for (int k = 0; k < 4; k++) begin
            check_val("rst2_count", 32'(count_o[k]), 0);
            check_val("rst2_tc", 32'(tc_o[k]), 0);
            check_val("rst2_ovf", 32'(ovf_o[k]), 0);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 1, 1, 0, 4'd0, 0);
            check_val("post_rst_pre", 32'(count_o[2]), (i == 3) ? 32'd1 : 32'd0);
            check_val("post_rst_wrap", 32'(count_o[0]), 32'(i));
        end

        check_val("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
